// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial a - b - bin, LSB first through a 1-bit full-subtractor slice
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bor
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] ra, rb, r;
  logic [CW-1:0] cnt;
  logic brw, d, bnext;
  assign d = ra[0] ^ rb[0] ^ brw;
  assign bnext = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & brw);
  always_comb begin
    state_nx = IDLE;
    busy = 1'b0;
    done = 1'b0;
    state_nx = state == IDLE  ? (start ? SHIFT : IDLE) :
               state == SHIFT ? (cnt == LAST ? DONE : SHIFT) : IDLE;
    busy = state == SHIFT || state == DONE;
    done = state == DONE;
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (!rst_n) begin
      ra <= '0;
      rb <= '0;
      r <= '0;
      brw <= 1'b0;
      cnt <= '0;
      diff <= '0;
      bor <= 1'b0;
    end else if (state == IDLE && start) begin
      ra <= a;
      rb <= b;
      brw <= bin;
      r <= '0;
      cnt <= '0;
    end else if (state == SHIFT) begin
      ra <= ra >> 1;
      rb <= rb >> 1;
      r <= {d, r[WIDTH-1:1]};
      brw <= bnext;
      cnt <= cnt + 1'b1;
      if (cnt == LAST) begin
        diff <= {d, r[WIDTH-1:1]};
        bor <= bnext;
      end
    end
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl: directed and random checks of serial_sub_ctrl at WIDTH 8 and 4
module tb_serial_sub_ctrl;
  logic clk = 1'b0;
  logic rst8, start8, bin8, busy8, done8, bor8;
  logic [7:0] a8, b8, diff8;
  logic rst4, start4, bin4, busy4, done4, bor4;
  logic [3:0] a4, b4, diff4;
  int vectors = 0, errs = 0;
  logic [7:0] e_d8 = '0;
  logic e_b8 = 1'b0;
  logic [3:0] e_d4 = '0;
  logic e_b4 = 1'b0;
  logic [7:0] qa [41], qb [41];
  logic qi [41];
  logic [32:0] m;

  serial_sub_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst8), .start(start8), .a(a8), .b(b8),
    .bin(bin8), .busy(busy8), .done(done8), .diff(diff8), .bor(bor8));
  serial_sub_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst4), .start(start4), .a(a4), .b(b4),
    .bin(bin4), .busy(busy4), .done(done4), .diff(diff4), .bor(bor4));

  always #5 clk = ~clk;

  // reference: plain signed arithmetic, borrow is the sign of a - b - bin
  function automatic logic [32:0] model(input int w, input longint av, input longint bv, input longint bi);
    longint x;
    logic [32:0] res;
    x = av - bv - bi;
    res[32] = x < 0;
    res[31:0] = 32'(x & ((longint'(1) << w) - 1));
    return res;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic bi);
    logic [32:0] r;
    @(negedge clk);
    start8 = 1'b1; a8 = av; b8 = bv; bin8 = bi;
    @(posedge clk);
    #1;
    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("busy8_shift", busy8, 1);
      chk("done8_shift", done8, 0);
      chk("diff8_hold", diff8, e_d8);
      chk("bor8_hold", bor8, e_b8);
      start8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
    end
    r = model(8, av, bv, bi);
    e_d8 = r[7:0]; e_b8 = r[32];
    @(negedge clk);
    start8 = 1'b0;
    chk("done8_pulse", done8, 1);
    chk("busy8_done", busy8, 1);
    chk("diff8", diff8, e_d8);
    chk("bor8", bor8, e_b8);
    @(negedge clk);
    chk("done8_idle", done8, 0);
    chk("busy8_idle", busy8, 0);
    chk("diff8_idle", diff8, e_d8);
  endtask

  task automatic op4(input logic [3:0] av, input logic [3:0] bv, input logic bi);
    logic [32:0] r;
    @(negedge clk);
    start4 = 1'b1; a4 = av; b4 = bv; bin4 = bi;
    @(posedge clk);
    #1;
    start4 = 1'($urandom); a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("busy4_shift", busy4, 1);
      chk("done4_shift", done4, 0);
      chk("diff4_hold", diff4, e_d4);
      chk("bor4_hold", bor4, e_b4);
    end
    r = model(4, av, bv, bi);
    e_d4 = r[3:0]; e_b4 = r[32];
    @(negedge clk);
    start4 = 1'b0;
    chk("done4_pulse", done4, 1);
    chk("diff4", diff4, e_d4);
    chk("bor4", bor4, e_b4);
    @(negedge clk);
    chk("done4_idle", done4, 0);
    chk("busy4_idle", busy4, 0);
  endtask

  initial begin
    rst8 = 1'b0; rst4 = 1'b0; start8 = 1'b1; start4 = 1'b1;
    a8 = 8'hAA; b8 = 8'h55; bin8 = 1'b1; a4 = 4'hA; b4 = 4'h5; bin4 = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_diff8", diff8, 0);
    chk("rst_bor8", bor8, 0);
    chk("rst_busy4", busy4, 0);
    chk("rst_diff4", diff4, 0);
    start8 = 1'b0; start4 = 1'b0; rst8 = 1'b1; rst4 = 1'b1;
    op8(8'h35, 8'h12, 1'b0);
    op8(8'h12, 8'h35, 1'b0);
    op8(8'h00, 8'h00, 1'b1);
    op8(8'hFF, 8'hFF, 1'b0);
    op8(8'h00, 8'hFF, 1'b1);
    for (int i = 0; i < 20; i++) op8(8'($urandom), 8'($urandom), 1'($urandom));
    // start held high: only every tenth edge is accepted
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      if (c > 0) begin
        chk("cont_busy", busy8, 32'(((c - 1) % 10) != 9));
        chk("cont_done", done8, 32'(((c - 1) % 10) == 8));
        if ((c - 1) % 10 == 8) begin
          m = model(8, qa[c-9], qb[c-9], qi[c-9]);
          e_d8 = m[7:0]; e_b8 = m[32];
          chk("cont_diff", diff8, e_d8);
          chk("cont_bor", bor8, e_b8);
        end
      end
      qa[c] = 8'($urandom); qb[c] = 8'($urandom); qi[c] = 1'($urandom);
      a8 = qa[c]; b8 = qb[c]; bin8 = qi[c]; start8 = c < 40;
    end
    op8(8'h35, 8'h12, 1'b0);
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst8 = 1'b0;
    @(negedge clk);
    rst8 = 1'b1;
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_diff", diff8, 0);
    chk("abort_bor", bor8, 0);
    e_d8 = '0; e_b8 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("abort_nodone", done8, 0);
    end
    op8(8'h80, 8'h01, 1'b0);
    for (int v = 0; v < 512; v++) op4(v[8:5], v[4:1], v[0]);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
